phs_avg_gain: RTL and testbench
===============================

# phs_avg_gain

Gain-register responder for the phase-averaging path: holds the complex PRL gains kx and ky and serves them on the interleaved-I/Q external address ports (kx_addr, ky_addr) that the phase averager drives. The host writes gains through a local-bus shadow bank, and a commit strobe transfers them to the active bank. The update lands only on an I/Q frame boundary, so the averager never sees a torn real/imag pair. An optional slew-limited ramp moves active gains toward their targets.

## Interface
- dw, 16: gain component width (signed).
- clk  in  1  sample clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- lb_write  in  1  host write strobe into shadow bank.
- lb_addr  in  2  shadow select: 0 kx real, 1 kx imag, 2 ky real, 3 ky imag.
- lb_data  in  dw  signed write data.
- commit  in  1  one-cycle strobe: copy shadow to target, arm update.
- ramp_step  in  dw-1  unsigned per-frame slew limit (ramp build only).
- kx_addr  in  1  1 selects real, 0 selects imag (follows iq).
- ky_addr  in  1  same for ky.
- kx  out  dw  active kx component selected by kx_addr.
- ky  out  dw  active ky component selected by ky_addr.
- busy  out  1  high while an update is pending or a ramp is incomplete.

## Operation
- Three register banks of four dw-bit entries each: shadow, target, and active.
- lb_write writes shadow[lb_addr] at the clock edge.
- commit copies all four shadow entries to target in one edge and sets pending_x and pending_y.
- lb_write and commit in the same cycle: target gets the pre-write shadow; the write still lands in shadow.
- commit while pending: target is overwritten and pending stays set. Only one apply occurs.
- Frame boundary for kx is the clock edge ending a cycle with kx_addr==0 (imag). The kx boundary is independent of the ky boundary (ky_addr).
- At a kx boundary with pending_x set:
  - Non-ramp build: active kx pair <= target kx pair; pending_x clears.
  - Ramp build: pending_x clears; ramping begins.
- Ramp: at each kx boundary, each kx component moves toward target by min(|target-active|, ramp_step). Difference is computed in dw+1 bits; no overflow or wrap.
- ky is handled identically on its own boundary.
- ramp_step==0: active holds, and busy stays high until a nonzero step arrives.
- A new commit during a ramp retargets the ramp; the ramp continues from the current active value.
- kx/ky: combinational mux of the active bank by address, so a zero-cycle read.
- busy = pending_x | pending_y | (active != target).

## Timing
- Reset (async assert, synchronous release) clears all banks and pending flags. Outputs after reset: kx=0, ky=0, busy=0.
- Reset mid-ramp or mid-pending: everything returns to zero and no apply occurs.
- lb_write edge t: shadow visible internally at t+1. It never reaches kx/ky without a commit.
- commit edge t: busy high from t+1. Active changes at the first boundary edge strictly after t.
- Worst case from commit to new active in the non-ramp build: 2 cycles with steady iq toggling.
- An address change updates kx/ky in the same cycle (combinational). Active-bank changes appear on the cycle after the boundary edge.
- If kx_addr holds constant, no kx boundary occurs and pending_x holds.

## Configuration
- PHS_GAIN_RAMP_EN defined: slew-limited ramp is active and ramp_step is used.
- PHS_GAIN_RAMP_EN undefined: active jumps to target at the boundary, ramp_step is ignored, and ramp logic is absent.

## Test plan
- Reset then toggle kx_addr -> kx=0, ky=0, busy=0 for every address.
- Write 0x1000, 0x0800, 0x7fff, 0x8000 to addresses 0-3, commit, iq toggling 1,0 -> after the first imag-ending edge, kx=0x1000 at addr 1 and 0x0800 at addr 0; ky=0x7fff/0x8000; busy falls.
- Hold kx_addr=1 for 10 cycles after commit -> kx stays old and busy=1. After one addr-0 cycle, kx updates as a whole pair.
- Same-cycle lb_write(addr 0, 0x2222) and commit with shadow[0]=0x1111 -> active real becomes 0x1111; a second commit yields 0x2222.
- Ramp build: active 0, target 0x0100, ramp_step 0x40 -> real goes 0x40, 0x80, 0xc0, 0x100 on successive boundaries; busy clears after the fourth. Target 0x7fff from 0x8000 with step 0x7fff -> no wrap.
- Deassert reset_n mid-ramp asynchronously -> kx=0 and busy=0 immediately. No residual apply after release.

Source files
------------

// File: rtl/phs_avg_gain_if.sv
// Host and averager port bundle for the phase-averaging gain register.
// Host side writes/commits gains; averager side reads interleaved I/Q.
interface phs_avg_gain_if #(
  parameter int DW = 16
);
  logic                 lb_write;
  logic [1:0]           lb_addr;
  logic signed [DW-1:0] lb_data;
  logic                 commit;
  logic [DW-2:0]        ramp_step;
  logic                 kx_addr;
  logic                 ky_addr;
  logic signed [DW-1:0] kx;
  logic signed [DW-1:0] ky;
  logic                 busy;

  modport master (
    output lb_write, lb_addr, lb_data, commit, ramp_step,
    output kx_addr, ky_addr,
    input  kx, ky, busy
  );

  modport slave (
    input  lb_write, lb_addr, lb_data, commit, ramp_step,
    input  kx_addr, ky_addr,
    output kx, ky, busy
  );
endinterface

// File: rtl/phs_avg_gain.sv
// Shadow/target/active gain banks with I/Q-frame-aligned apply.
// PHS_GAIN_RAMP_EN enables a slew-limited ramp toward the target.
module phs_avg_gain #(
  parameter int DW = 16
) (
  input logic           clk,
  input logic           reset_n,
  phs_avg_gain_if.slave bus
);

  logic signed [DW-1:0] shadow [4];
  logic signed [DW-1:0] target [4];
  logic signed [DW-1:0] active [4];
  logic signed [DW-1:0] nxt    [4];
  logic                 pending_x;
  logic                 pending_y;
  logic                 bnd_x;
  logic                 bnd_y;
  logic                 diff;

`ifdef PHS_GAIN_RAMP_EN
  // Difference in DW+1 bits so the step never wraps.
  function automatic logic [DW-1:0] ramp_next(
    input logic [DW-1:0] a,
    input logic [DW-1:0] t,
    input logic [DW-2:0] s
  );
    logic [DW:0] d;
    logic [DW:0] m;
    logic [DW:0] se;
    logic [DW:0] r;
    d  = {t[DW-1], t} - {a[DW-1], a};
    m  = d[DW] ? (~d + 1'b1) : d;
    se = {2'b00, s};
    if (m <= se)
      r = {t[DW-1], t};
    else if (d[DW])
      r = {a[DW-1], a} - se;
    else
      r = {a[DW-1], a} + se;
    return r[DW-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++)
      nxt[i] = ramp_next(active[i], target[i], bus.ramp_step);
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++)
      nxt[i] = target[i];
  end
`endif

  // A boundary is the edge that ends an imag (addr 0) cycle.
  assign bnd_x = ~bus.kx_addr;
  assign bnd_y = ~bus.ky_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        target[i] <= '0;
        active[i] <= '0;
      end
      pending_x <= 1'b0;
      pending_y <= 1'b0;
    end else begin
      if (bus.lb_write)
        shadow[bus.lb_addr] <= bus.lb_data;
      if (bus.commit) begin
        for (int i = 0; i < 4; i++)
          target[i] <= shadow[i];
      end
      pending_x <= bus.commit | (pending_x & ~bnd_x);
      pending_y <= bus.commit | (pending_y & ~bnd_y);
      // A commit edge defers the apply to the next boundary.
      if (bnd_x & ~bus.commit) begin
        active[0] <= nxt[0];
        active[1] <= nxt[1];
      end
      if (bnd_y & ~bus.commit) begin
        active[2] <= nxt[2];
        active[3] <= nxt[3];
      end
    end
  end

  always_comb begin
    diff = 1'b0;
    for (int i = 0; i < 4; i++)
      diff = diff | (active[i] != target[i]);
  end

  assign bus.kx   = bus.kx_addr ? active[0] : active[1];
  assign bus.ky   = bus.ky_addr ? active[2] : active[3];
  assign bus.busy = pending_x | pending_y | diff;

endmodule

// File: tb/tb_phs_avg_gain.sv
// Directed bench for phs_avg_gain; covers both builds of PHS_GAIN_RAMP_EN.
module tb_phs_avg_gain;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  phs_avg_gain_if #(.DW(16)) bus ();

  phs_avg_gain #(.DW(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.lb_write = 1'b1;
    bus.lb_addr  = a;
    bus.lb_data  = d;
    cyc();
    bus.lb_write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 2; a++) begin
      bus.kx_addr = a[0];
      bus.ky_addr = a[0];
      cyc();
      checks++;
      if (bus.kx !== 16'h0000) begin
        errors++;
        $display("FAIL reset_kx addr=%0d got %h exp 0000", a, bus.kx);
      end
      checks++;
      if (bus.ky !== 16'h0000) begin
        errors++;
        $display("FAIL reset_ky addr=%0d got %h exp 0000", a, bus.ky);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy addr=%0d got %b exp 0", a, bus.busy);
      end
    end
  endtask

  task automatic test_commit();
    bus.kx_addr = 1'b1;
    bus.ky_addr = 1'b1;
    wr(2'd0, 16'h1000);
    wr(2'd1, 16'h0800);
    wr(2'd2, 16'h7fff);
    wr(2'd3, 16'h8000);
    checks++;
    if (bus.kx !== 16'h0000) begin
      errors++;
      $display("FAIL shadow_leak got %h exp 0000", bus.kx);
    end
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.kx !== 16'h0000) begin
      errors++;
      $display("FAIL commit_pend busy=%b kx=%h exp 1/0000", bus.busy, bus.kx);
    end
    bus.kx_addr = 1'b0;
    bus.ky_addr = 1'b0;
    cyc();
`ifdef PHS_GAIN_RAMP_EN
    cyc();
`endif
    bus.kx_addr = 1'b1;
    bus.ky_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h1000) begin
      errors++;
      $display("FAIL kx_real got %h exp 1000", bus.kx);
    end
    checks++;
    if (bus.ky !== 16'h7fff) begin
      errors++;
      $display("FAIL ky_real got %h exp 7fff", bus.ky);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL commit_busy got %b exp 0", bus.busy);
    end
    bus.kx_addr = 1'b0;
    bus.ky_addr = 1'b0;
    #1;
    checks++;
    if (bus.kx !== 16'h0800) begin
      errors++;
      $display("FAIL kx_imag got %h exp 0800", bus.kx);
    end
    checks++;
    if (bus.ky !== 16'h8000) begin
      errors++;
      $display("FAIL ky_imag got %h exp 8000", bus.ky);
    end
  endtask

  task automatic test_hold();
    bus.kx_addr = 1'b1;
    bus.ky_addr = 1'b0;
    wr(2'd0, 16'h1234);
    wr(2'd1, 16'h5678);
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (bus.kx !== 16'h1000 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold cyc=%0d kx=%h busy=%b exp 1000/1", i, bus.kx, bus.busy);
      end
    end
    bus.kx_addr = 1'b0;
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h1234) begin
      errors++;
      $display("FAIL hold_real got %h exp 1234", bus.kx);
    end
    bus.kx_addr = 1'b0;
    #1;
    checks++;
    if (bus.kx !== 16'h5678 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_imag kx=%h busy=%b exp 5678/0", bus.kx, bus.busy);
    end
  endtask

  task automatic test_same_cycle();
    bus.kx_addr = 1'b1;
    wr(2'd0, 16'h1111);
    bus.lb_write = 1'b1;
    bus.lb_addr  = 2'd0;
    bus.lb_data  = 16'h2222;
    bus.commit   = 1'b1;
    cyc();
    bus.lb_write = 1'b0;
    bus.commit   = 1'b0;
    bus.kx_addr  = 1'b0;
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h1111) begin
      errors++;
      $display("FAIL same_cyc1 got %h exp 1111", bus.kx);
    end
    bus.commit = 1'b1;
    cyc();
    bus.commit  = 1'b0;
    bus.kx_addr = 1'b0;
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h2222 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL same_cyc2 kx=%h busy=%b exp 2222/0", bus.kx, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.kx_addr = 1'b1;
    bus.ky_addr = 1'b1;
    bus.ramp_step = 15'd1;
    wr(2'd0, 16'h0100);
    bus.commit = 1'b1;
    cyc();
    bus.commit  = 1'b0;
    bus.kx_addr = 1'b0;
    cyc();
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b exp 1", bus.busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.kx !== 16'h0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst kx=%h busy=%b exp 0000/0", bus.kx, bus.busy);
    end
    cyc();
    reset_n = 1'b1;
    bus.kx_addr = 1'b0;
    bus.ky_addr = 1'b0;
    cyc();
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst kx=%h busy=%b exp 0000/0", bus.kx, bus.busy);
    end
    bus.ramp_step = 15'h7fff;
  endtask

`ifdef PHS_GAIN_RAMP_EN
  task automatic test_ramp();
    logic [15:0] exp_a [4];
    logic [15:0] exp_w [5];
    exp_a = '{16'h0040, 16'h0080, 16'h00c0, 16'h0100};
    exp_w = '{16'h8101, 16'h8000, 16'hffff, 16'h7ffe, 16'h7fff};
    do_reset();
    bus.kx_addr = 1'b0;
    bus.ky_addr = 1'b0;
    bus.ramp_step = 15'h0040;
    wr(2'd0, 16'h0100);
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.kx_addr = 1'b1;
      #1;
      checks++;
      if (bus.kx !== exp_a[i] || bus.busy !== (i != 3)) begin
        errors++;
        $display("FAIL ramp step=%0d kx=%h busy=%b exp %h", i, bus.kx, bus.busy, exp_a[i]);
      end
      bus.kx_addr = 1'b0;
    end
    bus.ramp_step = 15'h7fff;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) wr(2'd0, 16'h8000);
      if (i == 2) wr(2'd0, 16'h7fff);
      if (i == 0 || i == 2) begin
        bus.commit = 1'b1;
        cyc();
        bus.commit = 1'b0;
      end
      cyc();
      bus.kx_addr = 1'b1;
      #1;
      checks++;
      if (bus.kx !== exp_w[i]) begin
        errors++;
        $display("FAIL ramp_wrap step=%0d kx=%h exp %h", i, bus.kx, exp_w[i]);
      end
      bus.kx_addr = 1'b0;
    end
    bus.ramp_step = 15'd0;
    wr(2'd0, 16'h0000);
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
    cyc();
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h7fff || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ramp_zero kx=%h busy=%b exp 7fff/1", bus.kx, bus.busy);
    end
    bus.kx_addr = 1'b0;
    bus.ramp_step = 15'h7fff;
    cyc();
    bus.kx_addr = 1'b1;
    #1;
    checks++;
    if (bus.kx !== 16'h0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ramp_resume kx=%h busy=%b exp 0000/0", bus.kx, bus.busy);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.lb_write  = 1'b0;
    bus.lb_addr   = 2'd0;
    bus.lb_data   = 16'h0000;
    bus.commit    = 1'b0;
    bus.ramp_step = 15'h7fff;
    bus.kx_addr   = 1'b1;
    bus.ky_addr   = 1'b1;
    test_reset();
    test_commit();
    test_hold();
    test_same_cycle();
`ifdef PHS_GAIN_RAMP_EN
    test_ramp();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
